mem_arbiter: RTL and testbench

- Sits directly downstream of the pipelined processor core's two memory ports: instruction fetch (pc_addr/im_command) and data (proc2Dmem_*).
- Merges both ports onto a single-ported external memory bus with a variable-latency ack handshake.
- Data port has priority; a streak counter guarantees fetch forward progress.
- Returns the instruction word or load data to the core with a one-cycle valid pulse; the core stalls its port until that pulse.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the core's fetch/data ports and the single external memory bus.
// The arbiter takes the slave view; the core and memory side take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_addr;
    logic [1:0]        im_command;
    logic [DATA_W-1:0] instruction;
    logic              im_valid;

    logic [ADDR_W-1:0] proc2Dmem_addr;
    logic [1:0]        proc2Dmem_command;
    logic [DATA_W-1:0] proc2mem_data;
    logic [DATA_W-1:0] mem2proc_data;
    logic              dmem_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_command;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  pc_addr, im_command, proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
        input  mem_rdata, mem_ack,
        output instruction, im_valid, mem2proc_data, dmem_valid,
        output mem_addr, mem_command, mem_wdata
    );

    modport master (
        output pc_addr, im_command, proc2Dmem_addr, proc2Dmem_command, proc2mem_data,
        output mem_rdata, mem_ack,
        input  instruction, im_valid, mem2proc_data, dmem_valid,
        input  mem_addr, mem_command, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Merges the core's fetch and data ports onto one single-ported memory bus.
// Data wins ties, but a streak counter forces a fetch grant after MAX_DATA_STREAK data grants.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        streak_q;
    logic              port_data_q;
    logic [DATA_W-1:0] instruction_q;
    logic              im_valid_q;
    logic [DATA_W-1:0] mem2proc_data_q;
    logic              dmem_valid_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [1:0]        mem_command_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic       fetch_req;
    logic       data_req;
    logic       grant_data_d;
    logic [3:0] streak_d;

    // Commands outside the legal set for a port read as no request.
    always_comb begin
        fetch_req    = (bus.im_command == CMD_LOAD);
        data_req     = (bus.proc2Dmem_command == CMD_LOAD) ||
                       (bus.proc2Dmem_command == CMD_STORE);
        grant_data_d = data_req;
        streak_d     = 4'd0;
        if (fetch_req && data_req) begin
            if (streak_q < MAX_STREAK) begin
                grant_data_d = 1'b1;
                streak_d     = streak_q + 4'd1;
            end else begin
                grant_data_d = 1'b0;
                streak_d     = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            streak_q        <= 4'd0;
            port_data_q     <= 1'b0;
            instruction_q   <= '0;
            im_valid_q      <= 1'b0;
            mem2proc_data_q <= '0;
            dmem_valid_q    <= 1'b0;
            mem_addr_q      <= '0;
            mem_command_q   <= CMD_NONE;
            mem_wdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_req || data_req) begin
                        streak_q    <= streak_d;
                        port_data_q <= grant_data_d;
                        if (grant_data_d) begin
                            mem_addr_q    <= bus.proc2Dmem_addr;
                            mem_command_q <= bus.proc2Dmem_command;
                            mem_wdata_q   <= bus.proc2mem_data;
                        end else begin
                            mem_addr_q    <= bus.pc_addr;
                            mem_command_q <= CMD_LOAD;
                            mem_wdata_q   <= '0;
                        end
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Bus stays frozen until the memory acknowledges, however long that takes.
                    if (bus.mem_ack) begin
                        mem_command_q <= CMD_NONE;
                        if (port_data_q) begin
                            dmem_valid_q <= 1'b1;
                            if (mem_command_q == CMD_LOAD) mem2proc_data_q <= bus.mem_rdata;
                        end else begin
                            im_valid_q    <= 1'b1;
                            instruction_q <= bus.mem_rdata;
                        end
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    im_valid_q   <= 1'b0;
                    dmem_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instruction   = instruction_q;
    assign bus.im_valid      = im_valid_q;
    assign bus.mem2proc_data = mem2proc_data_q;
    assign bus.dmem_valid    = dmem_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_command   = mem_command_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked against
// a transaction-level model of the arbitration and response rules.
module tb_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic clk;
    logic rst;
    int checks = 0;
    int errors = 0;

    int          model_streak;
    logic [31:0] exp_instr;
    logic [31:0] exp_m2p;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge with requests already applied. Returns what the bus and core saw.
    task automatic do_txn(input int lat, input logic [31:0] rdata,
                          output logic [31:0] g_addr, output logic [1:0] g_cmd,
                          output logic [31:0] g_wdata, output logic early,
                          output logic v_im, output logic v_d,
                          output logic [31:0] o_instr, output logic [31:0] o_m2p,
                          output logic [1:0] cmd_after, output logic v_after);
        early = 1'b0;
        @(negedge clk);
        g_addr = bus.mem_addr; g_cmd = bus.mem_command; g_wdata = bus.mem_wdata;
        v_im = 1'b0; v_d = 1'b0; o_instr = bus.instruction; o_m2p = bus.mem2proc_data;
        cmd_after = g_cmd; v_after = 1'b0;
        if (bus.im_valid || bus.dmem_valid) early = 1'b1;
        if (g_cmd == 2'd0) return;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (bus.im_valid || bus.dmem_valid || bus.mem_command !== g_cmd) early = 1'b1;
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_ack = 1'($urandom % 2); bus.mem_rdata = $urandom;
        v_im = bus.im_valid; v_d = bus.dmem_valid;
        o_instr = bus.instruction; o_m2p = bus.mem2proc_data; cmd_after = bus.mem_command;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        v_after = bus.im_valid | bus.dmem_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pc_addr = 32'h0; bus.im_command = 2'd1; bus.proc2Dmem_addr = 32'h0;
        bus.proc2Dmem_command = 2'd0; bus.proc2mem_data = 32'h0;
        bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.instruction, bus.mem2proc_data, bus.mem_addr, bus.mem_wdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%h exp 0", bus.instruction, bus.mem2proc_data,
                     bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if ({bus.im_valid, bus.dmem_valid, bus.mem_command} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%0d exp 000", bus.im_valid, bus.dmem_valid, bus.mem_command);
        end
        bus.im_command = 2'd0;
        rst = 1'b1;
        model_streak = 0; exp_instr = 32'h0; exp_m2p = 32'h0;
    endtask

    task automatic test_single_fetch();
        logic [31:0] ga, gw, oi, om; logic [1:0] gc, ca; logic e, vi, vd, va;
        bus.pc_addr = 32'h100; bus.im_command = 2'd1;
        do_txn(4, 32'h00500093, ga, gc, gw, e, vi, vd, oi, om, ca, va);
        model_streak = 0; exp_instr = 32'h00500093;
        checks++;
        if (ga !== 32'h100 || gc !== 2'd1) begin
            errors++; $display("FAIL fetch_grant got %h/%0d exp 100/1", ga, gc);
        end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL fetch_early got %b exp 0", e); end
        checks++;
        if (vi !== 1'b1 || vd !== 1'b0 || oi !== exp_instr) begin
            errors++; $display("FAIL fetch_resp got v=%b%b instr=%h exp v=10 instr=%h", vi, vd, oi, exp_instr);
        end
        checks++;
        if (va !== 1'b0 || ca !== 2'd0) begin
            errors++; $display("FAIL fetch_pulse got valid_after=%b cmd=%0d exp 0/0", va, ca);
        end
        bus.im_command = 2'd0;
    endtask

    task automatic test_store_load();
        logic [31:0] ga, gw, oi, om; logic [1:0] gc, ca; logic e, vi, vd, va;
        bus.proc2Dmem_addr = 32'h2000; bus.proc2Dmem_command = 2'd2; bus.proc2mem_data = 32'hDEADBEEF;
        do_txn(1, 32'h12345678, ga, gc, gw, e, vi, vd, oi, om, ca, va);
        checks++;
        if (ga !== 32'h2000 || gc !== 2'd2 || gw !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_grant got %h/%0d/%h exp 2000/2/deadbeef", ga, gc, gw);
        end
        checks++;
        if (vd !== 1'b1 || vi !== 1'b0 || om !== 32'h0 || e !== 1'b0 || va !== 1'b0) begin
            errors++; $display("FAIL store_resp got v=%b%b m2p=%h exp v=01 m2p=0", vi, vd, om);
        end
        bus.proc2Dmem_command = 2'd1; bus.proc2mem_data = 32'h0;
        do_txn(1, 32'hDEADBEEF, ga, gc, gw, e, vi, vd, oi, om, ca, va);
        exp_m2p = 32'hDEADBEEF; model_streak = 0;
        checks++;
        if (ga !== 32'h2000 || gc !== 2'd1) begin
            errors++; $display("FAIL load_grant got %h/%0d exp 2000/1", ga, gc);
        end
        checks++;
        if (vd !== 1'b1 || vi !== 1'b0 || om !== exp_m2p || oi !== exp_instr || va !== 1'b0) begin
            errors++; $display("FAIL load_resp got v=%b%b m2p=%h instr=%h exp v=01 m2p=%h instr=%h",
                               vi, vd, om, oi, exp_m2p, exp_instr);
        end
        bus.proc2Dmem_command = 2'd0;
    endtask

    task automatic test_priority();
        logic [31:0] ga, gw, oi, om; logic [1:0] gc, ca; logic e, vi, vd, va;
        bus.pc_addr = 32'h300; bus.im_command = 2'd1;
        bus.proc2Dmem_addr = 32'h4000; bus.proc2Dmem_command = 2'd1;
        do_txn(2, 32'hA1A1A1A1, ga, gc, gw, e, vi, vd, oi, om, ca, va);
        exp_m2p = 32'hA1A1A1A1;
        checks++;
        if (ga !== 32'h4000 || vd !== 1'b1 || vi !== 1'b0 || om !== exp_m2p) begin
            errors++; $display("FAIL prio_data got addr=%h v=%b%b m2p=%h exp addr=4000 v=01", ga, vi, vd, om);
        end
        bus.proc2Dmem_command = 2'd0;
        do_txn(1, 32'hB2B2B2B2, ga, gc, gw, e, vi, vd, oi, om, ca, va);
        exp_instr = 32'hB2B2B2B2; model_streak = 0;
        checks++;
        if (ga !== 32'h300 || gc !== 2'd1 || vi !== 1'b1 || vd !== 1'b0 || oi !== exp_instr || om !== exp_m2p) begin
            errors++; $display("FAIL prio_fetch got addr=%h v=%b%b instr=%h exp addr=300 v=10 instr=%h",
                               ga, vi, vd, oi, exp_instr);
        end
        bus.im_command = 2'd0;
    endtask

    task automatic test_starvation();
        logic [31:0] ga, gw, oi, om, rd, f_addr, d_addr; logic [1:0] gc, ca; logic e, vi, vd, va;
        bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int d_count = 0;
        int first_im = -1;
        f_addr = 32'h1000;
        bus.pc_addr = f_addr; bus.im_command = 2'd1; bus.proc2Dmem_command = 2'd1;
        for (int k = 0; k < 10; k++) begin
            d_addr = 32'h8000 + 32'(k * 4);
            bus.proc2Dmem_addr = d_addr;
            rd = $urandom;
            do_txn(1, rd, ga, gc, gw, e, vi, vd, oi, om, ca, va);
            if (exp_seq[k]) exp_m2p = rd; else exp_instr = rd;
            checks++;
            if (vd !== exp_seq[k] || vi !== !exp_seq[k] || ga !== (exp_seq[k] ? d_addr : f_addr)) begin
                errors++; $display("FAIL starve_order[%0d] got addr=%h v=%b%b exp addr=%h data=%b",
                                   k, ga, vi, vd, exp_seq[k] ? d_addr : f_addr, exp_seq[k]);
            end
            checks++;
            if (oi !== exp_instr || om !== exp_m2p) begin
                errors++; $display("FAIL starve_data[%0d] got %h/%h exp %h/%h", k, oi, om, exp_instr, exp_m2p);
            end
            if (vd === 1'b1) d_count++;
            if (vi === 1'b1) begin
                if (first_im < 0) first_im = d_count;
                f_addr = f_addr + 32'd4;
                bus.pc_addr = f_addr;
            end
        end
        checks++;
        if (first_im != MAXS) begin
            errors++; $display("FAIL starve_bound got %0d data pulses before fetch exp %0d", first_im, MAXS);
        end
        model_streak = 0;
        bus.im_command = 2'd0; bus.proc2Dmem_command = 2'd0;
    endtask

    task automatic test_illegal();
        bus.im_command = 2'd2; bus.proc2Dmem_command = 2'd3;
        bus.pc_addr = $urandom; bus.proc2Dmem_addr = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_command !== 2'd0 || bus.im_valid !== 1'b0 || bus.dmem_valid !== 1'b0) begin
                errors++; $display("FAIL illegal[%0d] got cmd=%0d v=%b%b exp 0/00", i,
                                   bus.mem_command, bus.im_valid, bus.dmem_valid);
            end
        end
        bus.im_command = 2'd0; bus.proc2Dmem_command = 2'd0;
    endtask

    task automatic test_reset_mid_busy();
        bus.pc_addr = 32'h5000; bus.im_command = 2'd1;
        @(negedge clk);
        checks++;
        if (bus.mem_command !== 2'd1 || bus.mem_addr !== 32'h5000) begin
            errors++; $display("FAIL rstbusy_grant got %h/%0d exp 5000/1", bus.mem_addr, bus.mem_command);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.instruction, bus.mem2proc_data, bus.mem_addr, bus.mem_wdata} !== 128'h0 ||
            {bus.im_valid, bus.dmem_valid, bus.mem_command} !== 4'b0) begin
            errors++; $display("FAIL rstbusy_async got instr=%h m2p=%h addr=%h cmd=%0d exp all 0",
                               bus.instruction, bus.mem2proc_data, bus.mem_addr, bus.mem_command);
        end
        bus.im_command = 2'd0;
        @(negedge clk);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.im_valid !== 1'b0 || bus.dmem_valid !== 1'b0 || bus.mem_command !== 2'd0 ||
                bus.instruction !== 32'h0) begin
                errors++; $display("FAIL rstbusy_stale[%0d] got v=%b%b cmd=%0d instr=%h exp 00/0/0", i,
                                   bus.im_valid, bus.dmem_valid, bus.mem_command, bus.instruction);
            end
        end
        bus.mem_ack = 1'b0;
        model_streak = 0; exp_instr = 32'h0; exp_m2p = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] ga, gw, oi, om, rd, f_addr, d_addr, d_wdata, exp_addr;
        logic [1:0] gc, ca, d_cmd, exp_cmd; logic e, vi, vd, va;
        bit f_pend = 0;
        bit d_pend = 0;
        bit exp_data;
        f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_cmd = 2'd1;
        for (int it = 0; it < 80; it++) begin
            if (!f_pend && ($urandom % 2) == 1) begin f_pend = 1; f_addr = $urandom; end
            if (!d_pend && ($urandom % 2) == 1) begin
                d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
                d_cmd = (($urandom % 2) == 1) ? 2'd1 : 2'd2;
            end
            bus.pc_addr = f_pend ? f_addr : $urandom;
            bus.im_command = f_pend ? 2'd1 : 2'($urandom_range(2, 4) % 4);
            bus.proc2Dmem_addr = d_pend ? d_addr : $urandom;
            bus.proc2Dmem_command = d_pend ? d_cmd : ((($urandom % 2) == 1) ? 2'd3 : 2'd0);
            bus.proc2mem_data = d_pend ? d_wdata : $urandom;
            if (!f_pend && !d_pend) begin
                @(negedge clk);
                checks++;
                if (bus.mem_command !== 2'd0 || bus.im_valid !== 1'b0 || bus.dmem_valid !== 1'b0) begin
                    errors++; $display("FAIL rand_idle[%0d] got cmd=%0d v=%b%b exp 0/00", it,
                                       bus.mem_command, bus.im_valid, bus.dmem_valid);
                end
                continue;
            end
            exp_data = d_pend && (!f_pend || model_streak < MAXS);
            if (f_pend && d_pend) model_streak = exp_data ? model_streak + 1 : 0;
            else model_streak = 0;
            exp_addr = exp_data ? d_addr : f_addr;
            exp_cmd = exp_data ? d_cmd : 2'd1;
            rd = $urandom;
            do_txn(int'($urandom_range(1, 4)), rd, ga, gc, gw, e, vi, vd, oi, om, ca, va);
            if (exp_data) begin
                if (d_cmd == 2'd1) exp_m2p = rd;
                d_pend = 0;
            end else begin
                exp_instr = rd;
                f_pend = 0;
            end
            checks++;
            if (ga !== exp_addr || gc !== exp_cmd || (exp_cmd == 2'd2 && gw !== d_wdata)) begin
                errors++; $display("FAIL rand_grant[%0d] got %h/%0d/%h exp %h/%0d/%h", it, ga, gc, gw,
                                   exp_addr, exp_cmd, d_wdata);
            end
            checks++;
            if (vd !== exp_data || vi !== !exp_data || e !== 1'b0 || va !== 1'b0 || ca !== 2'd0) begin
                errors++; $display("FAIL rand_valid[%0d] got v=%b%b early=%b after=%b cmd=%0d exp data=%b",
                                   it, vi, vd, e, va, ca, exp_data);
            end
            checks++;
            if (oi !== exp_instr || om !== exp_m2p) begin
                errors++; $display("FAIL rand_data[%0d] got %h/%h exp %h/%h", it, oi, om, exp_instr, exp_m2p);
            end
        end
        bus.im_command = 2'd0; bus.proc2Dmem_command = 2'd0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_priority();
        test_starvation();
        test_illegal();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
